reg_file_mp: RTL and testbench

Parametrised multi-port integer register file, the next generation of the RVSEED general-register block, for the superscalar core. It provides NRD combinational read ports and NWR write ports with a fixed write priority, optional same-cycle write-to-read bypass, and a hardware zero-initialisation sweep after reset or on request. It also provides a per-register pending scoreboard for producer tracking. Index 0 is constant zero. The block sits between decode (reads, reservations) and writeback (writes).

---
 rtl/rf_pkg.sv | 17 +
 rtl/rf_wr_resolve.sv | 30 +++
 rtl/reg_file_mp.sv | 134 +++++++++++++
 tb/tb_reg_file_mp.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// rf_pkg: shared types and defaults for the multi-port register file.
// State encoding, default geometry and the zero constant.
package rf_pkg;

  typedef enum logic {
    RF_INIT = 1'b0,
    RF_RUN  = 1'b1
  } rf_state_t;

  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 5;
  localparam int RF_NRD    = 2;
  localparam int RF_NWR    = 2;

  localparam logic [RF_DATA_W-1:0] RF_ZERO = '0;

endpackage

// File: rtl/rf_wr_resolve.sv
// rf_wr_resolve: priority scan of the write ports for one address.
// The highest-numbered enabled port that matches supplies the data.
module rf_wr_resolve
  import rf_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int NWR    = RF_NWR
) (
  input  logic [ADDR_W-1:0]     addr,
  input  logic [NWR-1:0]        wen,
  input  logic [NWR*ADDR_W-1:0] waddr,
  input  logic [NWR*DATA_W-1:0] wdata,
  output logic                  hit,
  output logic [DATA_W-1:0]     data
);

  // later ports overwrite earlier ones, giving top port priority
  always_comb begin
    hit  = 1'b0;
    data = '0;
    for (int k = 0; k < NWR; k++) begin
      if (wen[k] && (waddr[k*ADDR_W +: ADDR_W] == addr)) begin
        hit  = 1'b1;
        data = wdata[k*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-port integer register file with zero sweep,
// optional write-to-read bypass and a per-register pending scoreboard.
module reg_file_mp
  import rf_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int NRD    = RF_NRD,
  parameter int NWR    = RF_NWR,
  parameter int BYPASS = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr_req,
  output logic                  init_busy,
  input  logic [NWR-1:0]        wen,
  input  logic [NWR*ADDR_W-1:0] waddr,
  input  logic [NWR*DATA_W-1:0] wdata,
  input  logic [NRD*ADDR_W-1:0] raddr,
  output logic [NRD*DATA_W-1:0] rdata,
  input  logic                  rsv_en,
  input  logic [ADDR_W-1:0]     rsv_addr,
  output logic [NRD-1:0]        rd_pend
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = '1;
  localparam logic [DATA_W-1:0] ZERO = DATA_W'(RF_ZERO);

  rf_state_t         state;
  logic [ADDR_W-1:0] cnt;
  logic [DEPTH-1:0]  pend;
  logic              run;
  logic              wr_ok;

  logic [DATA_W-1:0] mem  [1:DEPTH-1];
  logic              whit [1:DEPTH-1];
  logic [DATA_W-1:0] wdat [1:DEPTH-1];

  assign run       = (state == RF_RUN);
  assign wr_ok     = run & ~clr_req;
  assign init_busy = ~run;

  for (genvar a = 1; a < DEPTH; a++) begin : g_ent
    rf_wr_resolve #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W),
      .NWR   (NWR)
    ) u_res (
      .addr (ADDR_W'(a)),
      .wen  (wen),
      .waddr(waddr),
      .wdata(wdata),
      .hit  (whit[a]),
      .data (wdat[a])
    );
  end

  // sequencer: sweep counter, run/init state and pending scoreboard
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RF_INIT;
      cnt   <= ADDR_W'(1);
      pend  <= '0;
    end else begin
      unique case (state)
        RF_INIT: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST) state <= RF_RUN;
        end
        RF_RUN: begin
          if (clr_req) begin
            state <= RF_INIT;
            cnt   <= ADDR_W'(1);
            pend  <= '0;
          end else begin
            for (int a = 1; a < DEPTH; a++) begin
              if (rsv_en && (rsv_addr == ADDR_W'(a)))
                pend[a] <= 1'b1;
              else if (whit[a])
                pend[a] <= 1'b0;
            end
          end
        end
        default: state <= RF_INIT;
      endcase
    end
  end

  // storage: sweep clears one entry per cycle, run applies writes
  always_ff @(posedge clk) begin
    for (int a = 1; a < DEPTH; a++) begin
      if (!run && (cnt == ADDR_W'(a)))
        mem[a] <= ZERO;
      else if (wr_ok && whit[a])
        mem[a] <= wdat[a];
    end
  end

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              ok;
    logic              bhit;
    logic [DATA_W-1:0] bdat;

    assign ra = raddr[p*ADDR_W +: ADDR_W];
    assign ok = run && (ra != '0);

    if (BYPASS != 0) begin : g_byp
      rf_wr_resolve #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .NWR   (NWR)
      ) u_byp (
        .addr (ra),
        .wen  (wen),
        .waddr(waddr),
        .wdata(wdata),
        .hit  (bhit),
        .data (bdat)
      );
    end else begin : g_nobyp
      assign bhit = 1'b0;
      assign bdat = ZERO;
    end

    assign rd_pend[p] = ok & pend[ra];
    assign rdata[p*DATA_W +: DATA_W] =
      !ok             ? ZERO :
      (wr_ok && bhit) ? bdat :
                        mem[ra];
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: directed plus random checks of reg_file_mp
// against an array model, for bypass and non-bypass builds.
module tb_reg_file_mp;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int NW = 2;
  localparam int DEPTH = 32;

  logic           clk;
  logic           rst;
  logic           clr_req;
  logic [NW-1:0]  wen;
  logic [NW*AW-1:0] waddr;
  logic [NW*DW-1:0] wdata;
  logic [NR*AW-1:0] raddr;
  logic           rsv_en;
  logic [AW-1:0]  rsv_addr;

  logic           busy1, busy0;
  logic [NR*DW-1:0] rdata1, rdata0;
  logic [NR-1:0]  pend1, pend0;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] mregs [DEPTH];
  bit            mpend [DEPTH];
  bit            mrun;
  int            mleft;

  reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR), .NWR(NW), .BYPASS(1)) dut1 (
    .clk(clk), .rst(rst), .clr_req(clr_req), .init_busy(busy1),
    .wen(wen), .waddr(waddr), .wdata(wdata), .raddr(raddr),
    .rdata(rdata1), .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rd_pend(pend1)
  );

  reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR), .NWR(NW), .BYPASS(0)) dut0 (
    .clk(clk), .rst(rst), .clr_req(clr_req), .init_busy(busy0),
    .wen(wen), .waddr(waddr), .wdata(wdata), .raddr(raddr),
    .rdata(rdata0), .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rd_pend(pend0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mrun = 1'b0;
    mleft = DEPTH - 1;
    for (int i = 0; i < DEPTH; i++) begin
      mregs[i] = '0;
      mpend[i] = 1'b0;
    end
  endtask

  task automatic model_step();
    logic [AW-1:0] a;
    if (!mrun) begin
      mleft--;
      if (mleft == 0) mrun = 1'b1;
    end else if (clr_req) begin
      model_reset();
    end else begin
      for (int k = 0; k < NW; k++) begin
        a = waddr[k*AW +: AW];
        if (wen[k] && a != 0) begin
          mregs[a] = wdata[k*DW +: DW];
          mpend[a] = 1'b0;
        end
      end
      if (rsv_en && rsv_addr != 0) mpend[rsv_addr] = 1'b1;
    end
  endtask

  function automatic logic [31:0] exp_rd(input int p, input bit byp);
    logic [AW-1:0] a;
    logic [31:0] v;
    a = raddr[p*AW +: AW];
    if (!mrun || a == 0) return '0;
    v = mregs[a];
    if (byp && !clr_req)
      for (int k = 0; k < NW; k++)
        if (wen[k] && waddr[k*AW +: AW] == a) v = wdata[k*DW +: DW];
    return v;
  endfunction

  function automatic logic exp_pend(input int p);
    logic [AW-1:0] a;
    a = raddr[p*AW +: AW];
    return mrun && a != 0 && mpend[a];
  endfunction

  task automatic check_outputs();
    chk("busy_byp", 32'(busy1), 32'(!mrun));
    chk("busy_nobyp", 32'(busy0), 32'(!mrun));
    for (int p = 0; p < NR; p++) begin
      chk($sformatf("rdata_byp%0d", p), rdata1[p*DW +: DW], exp_rd(p, 1'b1));
      chk($sformatf("rdata_nobyp%0d", p), rdata0[p*DW +: DW], exp_rd(p, 1'b0));
      chk($sformatf("pend_byp%0d", p), 32'(pend1[p]), 32'(exp_pend(p)));
      chk($sformatf("pend_nobyp%0d", p), 32'(pend0[p]), 32'(exp_pend(p)));
    end
  endtask

  task automatic cycle();
    if (rst) model_reset();
    #1;
    check_outputs();
    @(posedge clk);
    if (rst) model_reset();
    else model_step();
    #1;
  endtask

  task automatic idle();
    clr_req = 1'b0;
    wen = '0;
    waddr = '0;
    wdata = '0;
    raddr = '0;
    rsv_en = 1'b0;
    rsv_addr = '0;
  endtask

  task automatic rnd_in(input bit allow_clr);
    wen = NW'($urandom);
    for (int k = 0; k < NW; k++) begin
      waddr[k*AW +: AW] = AW'($urandom_range(0, 7));
      wdata[k*DW +: DW] = $urandom;
    end
    for (int p = 0; p < NR; p++)
      raddr[p*AW +: AW] = AW'($urandom_range(0, 7));
    rsv_en = ($urandom_range(0, 3) == 0);
    rsv_addr = AW'($urandom_range(0, 7));
    clr_req = allow_clr ? 1'($urandom) : 1'b0;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    model_reset();
    repeat (2) cycle();
    rst = 1'b0;

    repeat (DEPTH - 1) begin
      rnd_in(1'b1);
      cycle();
    end
    idle();
    raddr = {5'd1, 5'd31};
    #1;
    chk("run_after_sweep", 32'(busy1), 32'd0);
    chk("swept_r31", rdata1[31:0], 32'h0);
    cycle();

    wen = 2'b11;
    waddr = {5'd5, 5'd5};
    wdata = {32'h22, 32'h11};
    raddr = {5'd0, 5'd5};
    #1;
    chk("bypass_r5", rdata1[31:0], 32'h22);
    chk("nobypass_r5", rdata0[31:0], 32'h0);
    cycle();
    idle();
    raddr = {5'd5, 5'd5};
    #1;
    chk("reg5_byp", rdata1[31:0], 32'h22);
    chk("reg5_nobyp", rdata0[63:32], 32'h22);
    cycle();

    idle();
    wen = 2'b01;
    waddr = {5'd0, 5'd0};
    wdata = {32'h0, 32'hDEAD};
    rsv_en = 1'b1;
    rsv_addr = 5'd0;
    cycle();
    idle();
    #1;
    chk("zero_rd", rdata1[31:0], 32'h0);
    chk("zero_pend", 32'(pend1[0]), 32'd0);
    cycle();

    idle();
    rsv_en = 1'b1;
    rsv_addr = 5'd7;
    raddr = {5'd0, 5'd7};
    cycle();
    idle();
    raddr = {5'd0, 5'd7};
    #1;
    chk("rsv7_set", 32'(pend1[0]), 32'd1);
    wen = 2'b10;
    waddr = {5'd7, 5'd0};
    wdata = {32'h77, 32'h0};
    cycle();
    idle();
    raddr = {5'd7, 5'd7};
    #1;
    chk("rsv7_cleared", 32'(pend1[1]), 32'd0);
    chk("reg7_val", rdata0[31:0], 32'h77);
    rsv_en = 1'b1;
    rsv_addr = 5'd7;
    wen = 2'b01;
    waddr = {5'd0, 5'd7};
    wdata = {32'h0, 32'h78};
    cycle();
    idle();
    raddr = {5'd0, 5'd7};
    #1;
    chk("rsv7_set_wins", 32'(pend0[0]), 32'd1);
    cycle();

    repeat (400) begin
      rnd_in(1'b0);
      cycle();
    end

    idle();
    wen = 2'b01;
    waddr = {5'd0, 5'd3};
    wdata = {32'h0, 32'h5};
    cycle();
    idle();
    clr_req = 1'b1;
    wen = 2'b11;
    waddr = {5'd4, 5'd3};
    wdata = {32'h9, 32'h9};
    cycle();
    repeat (9) begin
      rnd_in(1'b1);
      cycle();
    end
    idle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    repeat (DEPTH - 1) begin
      rnd_in(1'b1);
      cycle();
    end
    idle();
    raddr = {5'd7, 5'd3};
    #1;
    chk("reg3_cleared", rdata1[31:0], 32'h0);
    chk("pend7_cleared", 32'(pend1[1]), 32'd0);
    cycle();

    repeat (200) begin
      rnd_in(1'b0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
